gppcu_lmem_dma: RTL and testbench

GPPCU_LMEM_DMA -- requirements
Module: gppcu_lmem_dma

---
 rtl/gppcu_lmem_dma.sv | 182 ++++++++++++++++++
 tb/tb_gppcu_lmem_dma.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gppcu_lmem_dma.sv
// DMA engine that moves words between a command/stream interface and per-thread local memories.
// Optional: define GPPCU_LMEM_DMA_BCAST_EN to let broadcast write commands select every thread memory.
module gppcu_lmem_dma #(
  parameter int unsigned NUM_THREAD = 4,
  parameter int unsigned WORD_BITS  = 10,
  localparam int unsigned TBW = (NUM_THREAD > 1) ? $clog2(NUM_THREAD) : 1
) (
  input  logic                       iACLK,
  input  logic                       inRST,
  input  logic                       iCMD_VALID,
  output logic                       oCMD_READY,
  input  logic                       iCMD_DIR,
  input  logic [TBW-1:0]             iCMD_THREAD,
  input  logic                       iCMD_BCAST,
  input  logic [WORD_BITS-1:0]       iCMD_ADDR,
  input  logic [WORD_BITS:0]         iCMD_LEN,
  input  logic                       iWD_VALID,
  output logic                       oWD_READY,
  input  logic [31:0]                iWD_DATA,
  output logic                       oRD_VALID,
  input  logic                       iRD_READY,
  output logic [31:0]                oRD_DATA,
  output logic                       oRD_LAST,
  output logic [NUM_THREAD-1:0]      oLMEMSEL,
  output logic                       oLMEMWREN,
  output logic [WORD_BITS-1:0]       oLMEMADDR,
  output logic [31:0]                oLMEMWDATA,
  input  logic [NUM_THREAD*32-1:0]   iLMEMRDATA,
  output logic                       oBUSY,
  output logic                       oDONE
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  localparam logic [WORD_BITS:0]   LMAX  = {1'b1, {WORD_BITS{1'b0}}};
  localparam logic [WORD_BITS:0]   LONE  = (WORD_BITS+1)'(1);
  localparam logic [WORD_BITS-1:0] AONE  = WORD_BITS'(1);

  state_t                  r_state;
  logic [TBW-1:0]          r_thread;
  logic [WORD_BITS-1:0]    r_addr;
  logic [WORD_BITS-1:0]    r_lmemaddr;
  logic [WORD_BITS:0]      r_remain;
  logic [WORD_BITS:0]      r_outleft;
  logic [NUM_THREAD-1:0]   r_sel;
  logic                    r_wren;
  logic [31:0]             r_wdata;
  logic [31:0]             r_fifo [4];
  logic [1:0]              r_wp;
  logic [1:0]              r_rp;
  logic [2:0]              r_cnt;
  logic                    r_rv0;
  logic                    r_rv1;

  logic [WORD_BITS:0]      w_len;
  logic [NUM_THREAD-1:0]   w_onehot;
  logic [NUM_THREAD-1:0]   w_sel_cmd;
  logic [31:0]             w_rdata;
  logic [3:0]              w_occ;
  logic                    w_issue;
  logic                    w_wd_hs;
  logic                    w_rd_valid;
  logic                    w_pop;
  logic                    w_push;

  assign w_len = (iCMD_LEN > LMAX) ? LMAX : iCMD_LEN;

  always_comb begin
    w_onehot = '0;
    for (int unsigned t = 0; t < NUM_THREAD; t++)
      if (iCMD_THREAD == TBW'(t)) w_onehot[t] = 1'b1;
  end

`ifdef GPPCU_LMEM_DMA_BCAST_EN
  assign w_sel_cmd = (iCMD_BCAST && !iCMD_DIR) ? '1 : w_onehot;
`else
  logic w_unused_bcast;
  assign w_unused_bcast = iCMD_BCAST;
  assign w_sel_cmd      = w_onehot;
`endif

  always_comb begin
    w_rdata = '0;
    for (int unsigned t = 0; t < NUM_THREAD; t++)
      if (r_thread == TBW'(t)) w_rdata = iLMEMRDATA[t*32 +: 32];
  end

  // Reads in flight occupy FIFO slots, so a captured word always has room.
  assign w_occ      = {1'b0, r_cnt} + {3'b000, r_rv0} + {3'b000, r_rv1};
  assign w_issue    = (r_state == S_READ) && (r_remain != '0) && (w_occ < 4'd4);
  assign w_wd_hs    = iWD_VALID && oWD_READY;
  assign w_rd_valid = (r_cnt != 3'd0);
  assign w_pop      = w_rd_valid && iRD_READY;
  assign w_push     = r_rv1;

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      r_state    <= S_IDLE;
      r_thread   <= '0;
      r_addr     <= '0;
      r_lmemaddr <= '0;
      r_remain   <= '0;
      r_outleft  <= '0;
      r_sel      <= '0;
      r_wren     <= 1'b0;
      r_wdata    <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_rv0      <= 1'b0;
      r_rv1      <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      r_rv0  <= w_issue;
      r_rv1  <= r_rv0;
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_pop};
      unique case (r_state)
        S_IDLE: begin
          if (iCMD_VALID) begin
            r_thread  <= iCMD_THREAD;
            r_addr    <= iCMD_ADDR;
            r_remain  <= w_len;
            r_outleft <= w_len;
            if (w_len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_sel   <= w_sel_cmd;
              r_state <= iCMD_DIR ? S_READ : S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (w_wd_hs) begin
            r_wren     <= 1'b1;
            r_lmemaddr <= r_addr;
            r_wdata    <= iWD_DATA;
            r_addr     <= r_addr + AONE;
            r_remain   <= r_remain - LONE;
          end else if (r_remain == '0) begin
            r_sel   <= '0;
            r_state <= S_DONE;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_lmemaddr <= r_addr;
            r_addr     <= r_addr + AONE;
            r_remain   <= r_remain - LONE;
          end
          if (w_pop) begin
            r_outleft <= r_outleft - LONE;
            if (r_outleft == LONE) begin
              r_sel   <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iACLK) begin
    if (w_push) r_fifo[r_wp] <= w_rdata;
  end

  assign oCMD_READY = (r_state == S_IDLE);
  assign oWD_READY  = (r_state == S_WRITE) && (r_remain != '0);
  assign oRD_VALID  = w_rd_valid;
  assign oRD_DATA   = w_rd_valid ? r_fifo[r_rp] : '0;
  assign oRD_LAST   = w_rd_valid && (r_outleft == LONE);
  assign oLMEMSEL   = r_sel;
  assign oLMEMWREN  = r_wren;
  assign oLMEMADDR  = r_lmemaddr;
  assign oLMEMWDATA = r_wdata;
  assign oBUSY      = (r_state != S_IDLE);
  assign oDONE      = (r_state == S_DONE);

endmodule

// File: tb/tb_gppcu_lmem_dma.sv
// Directed bench for gppcu_lmem_dma: scoreboard queues for lmem writes and read-stream beats.
module tb_gppcu_lmem_dma;
  localparam int unsigned NT = 4;
  localparam int unsigned WB = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_dir = 1'b0;
  logic [1:0]        cmd_thread = '0;
  logic              cmd_bcast = 1'b0;
  logic [WB-1:0]     cmd_addr = '0;
  logic [WB:0]       cmd_len = '0;
  logic              wd_valid = 1'b0;
  logic              wd_ready;
  logic [31:0]       wd_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b1;
  logic [31:0]       rd_data;
  logic              rd_last;
  logic [NT-1:0]     lm_sel;
  logic              lm_wren;
  logic [WB-1:0]     lm_addr;
  logic [31:0]       lm_wdata;
  logic [NT*32-1:0]  lm_rdata = '0;
  logic              busy;
  logic              done;

  gppcu_lmem_dma #(.NUM_THREAD(NT), .WORD_BITS(WB)) dut (
    .iACLK(clk), .inRST(rst_n),
    .iCMD_VALID(cmd_valid), .oCMD_READY(cmd_ready), .iCMD_DIR(cmd_dir),
    .iCMD_THREAD(cmd_thread), .iCMD_BCAST(cmd_bcast), .iCMD_ADDR(cmd_addr), .iCMD_LEN(cmd_len),
    .iWD_VALID(wd_valid), .oWD_READY(wd_ready), .iWD_DATA(wd_data),
    .oRD_VALID(rd_valid), .iRD_READY(rd_ready), .oRD_DATA(rd_data), .oRD_LAST(rd_last),
    .oLMEMSEL(lm_sel), .oLMEMWREN(lm_wren), .oLMEMADDR(lm_addr), .oLMEMWDATA(lm_wdata),
    .iLMEMRDATA(lm_rdata), .oBUSY(busy), .oDONE(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rexp(input int t, input int a);
    logic [3:0] tt;
    logic [WB-1:0] aa;
    tt = 4'(t);
    aa = WB'(a);
    return {tt, 18'b0, aa};
  endfunction

  // Each thread memory returns its tag and the previous cycle's address.
  always @(posedge clk)
    for (int t = 0; t < NT; t++) lm_rdata[t*32 +: 32] <= rexp(t, int'(lm_addr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [45:0] wq[$];
  logic [32:0] rq[$];
  int wr_cnt = 0, wr_first = 0, wr_last = 0;
  bit wr_mark = 0;
  int rd_cnt = 0, rd_first = 0, rd_last_cyc = 0, rd_vcnt = 0;
  bit rd_mark = 0;
  int done_cnt = 0, done_cyc = 0;
  bit prev_done = 0;
  bit prev_stall = 0;
  logic [33:0] prev_vec = '0;

  always @(negedge clk) begin
    if (lm_wren === 1'b1) begin
      wr_cnt++;
      wr_last = cyc;
      if (wr_mark) begin wr_first = cyc; wr_mark = 0; end
      chk("wr_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) chk("wr_beat", {lm_sel, lm_addr, lm_wdata}, wq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (prev_stall) chk("rd_stable", {rd_valid, rd_last, rd_data}, prev_vec);
    if (rd_valid === 1'b1) rd_vcnt++;
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      rd_cnt++;
      rd_last_cyc = cyc;
      if (rd_mark) begin rd_first = cyc; rd_mark = 0; end
      chk("rd_expected", 64'(rq.size() != 0), 64'd1);
      if (rq.size() != 0) chk("rd_beat", {rd_last, rd_data}, rq.pop_front());
    end
    prev_stall = (rd_valid === 1'b1) && (rd_ready === 1'b0) && (rst_n === 1'b1);
    prev_vec   = {rd_valid, rd_last, rd_data};
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_single_cycle", 64'(prev_done), 64'd0);
    end
    prev_done = (done === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, {cmd_ready, wd_ready, rd_valid, rd_last, busy, done, lm_wren}, 7'b1000000);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_sel"}, lm_sel, 4'd0);
    chk({tag, "_addr"}, lm_addr, 10'd0);
    chk({tag, "_wdata"}, lm_wdata, 32'd0);
  endtask

  task automatic send_cmd(input logic dir, input int thr, input logic bc, input int addr, input int len);
    for (int n = 0; n < 50 && cmd_ready !== 1'b1; n++) step();
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_dir = dir; cmd_thread = 2'(thr); cmd_bcast = bc;
    cmd_addr = WB'(addr); cmd_len = (WB+1)'(len); cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("cmd_accepted_busy", {cmd_ready, busy}, 2'b01);
  endtask

  task automatic send_word(input logic [31:0] d);
    bit hs;
    hs = 0;
    wd_data = d;
    wd_valid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      hs = (wd_ready === 1'b1);
      step();
    end
    chk("wd_handshake", 64'(hs), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int d0, input int bound);
    for (int n = 0; n < bound && done_cnt == d0; n++) step();
    chk(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  logic [3:0] bsel;
  int d0, w0, r0, v0;
  bit ok;

  initial begin
    repeat (2) step();
    check_reset("rst_init");
    rst_n = 1'b1;
    step();

    // write data offered while idle must not be taken
    wd_valid = 1'b1; wd_data = 32'hDEAD_BEEF;
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      chk("wd_ready_idle", wd_ready, 1'b0);
      step();
    end
    wd_valid = 1'b0;
    chk("wd_idle_no_write", 64'(wr_cnt - w0), 64'd0);

    // write thread 2 at 0x010, three words back-to-back
    wq.push_back({4'b0100, 10'h010, 32'hA});
    wq.push_back({4'b0100, 10'h011, 32'hB});
    wq.push_back({4'b0100, 10'h012, 32'hC});
    d0 = done_cnt; wr_mark = 1;
    send_cmd(1'b0, 2, 1'b0, 'h010, 3);
    send_word(32'hA); send_word(32'hB); send_word(32'hC);
    wd_valid = 1'b0;
    wait_done("w3_done", d0, 20);
    chk("w3_consecutive", 64'(wr_last - wr_first), 64'd2);
    chk("w3_done_timing", 64'(done_cyc - wr_last), 64'd1);
    chk("w3_queue_empty", 64'(wq.size()), 64'd0);

    // read thread 1 across the address wrap, ready held high
    for (int i = 0; i < 4; i++) rq.push_back({(i == 3), rexp(1, 'h3FE + i)});
    d0 = done_cnt; r0 = rd_cnt; rd_mark = 1;
    send_cmd(1'b1, 1, 1'b0, 'h3FE, 4);
    wait_done("r4_done", d0, 40);
    chk("r4_consecutive", 64'(rd_last_cyc - rd_first), 64'd3);
    chk("r4_count", 64'(rd_cnt - r0), 64'd4);
    chk("r4_queue_empty", 64'(rq.size()), 64'd0);

    // read 8 words with the consumer stalling every other cycle
    for (int i = 0; i < 8; i++) rq.push_back({(i == 7), rexp(0, 'h100 + i)});
    d0 = done_cnt; r0 = rd_cnt;
    send_cmd(1'b1, 0, 1'b0, 'h100, 8);
    for (int n = 0; n < 100 && done_cnt == d0; n++) begin
      rd_ready = ~rd_ready;
      step();
    end
    rd_ready = 1'b1;
    chk("r8_done", 64'(done_cnt - d0), 64'd1);
    chk("r8_count", 64'(rd_cnt - r0), 64'd8);
    chk("r8_queue_empty", 64'(rq.size()), 64'd0);

    // zero-length write and read
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt; w0 = wr_cnt; v0 = rd_vcnt;
      send_cmd(k[0], 3, 1'b0, 'h055, 0);
      ok = 0;
      for (int n = 0; n < 2 && !ok; n++) begin
        step();
        ok = (cmd_ready === 1'b1);
      end
      chk("len0_ready_again", 64'(ok), 64'd1);
      chk("len0_done", 64'(done_cnt - d0), 64'd1);
      chk("len0_no_wren", 64'(wr_cnt - w0), 64'd0);
      chk("len0_no_rd_valid", 64'(rd_vcnt - v0), 64'd0);
    end

    // oversized length saturates to the full memory depth
    for (int i = 0; i < 1024; i++) rq.push_back({(i == 1023), rexp(3, 'h200 + i)});
    d0 = done_cnt; r0 = rd_cnt;
    send_cmd(1'b1, 3, 1'b0, 'h200, 'h7FF);
    wait_done("sat_done", d0, 1200);
    chk("sat_count", 64'(rd_cnt - r0), 64'd1024);
    chk("sat_queue_empty", 64'(rq.size()), 64'd0);

    // broadcast write at the top address, then broadcast read
`ifdef GPPCU_LMEM_DMA_BCAST_EN
    bsel = 4'b1111;
`else
    bsel = 4'b1000;
`endif
    wq.push_back({bsel, 10'h3FF, 32'h11});
    wq.push_back({bsel, 10'h000, 32'h22});
    d0 = done_cnt;
    send_cmd(1'b0, 3, 1'b1, 'h3FF, 2);
    send_word(32'h11); send_word(32'h22);
    wd_valid = 1'b0;
    wait_done("bc_wr_done", d0, 20);
    chk("bc_wr_queue_empty", 64'(wq.size()), 64'd0);
    rq.push_back({1'b1, rexp(2, 'h005)});
    d0 = done_cnt;
    send_cmd(1'b1, 2, 1'b1, 'h005, 1);
    chk("bc_rd_sel", lm_sel, 4'b0100);
    wait_done("bc_rd_done", d0, 20);
    chk("bc_rd_queue_empty", 64'(rq.size()), 64'd0);

    // reset in the middle of a 16-word write after five words
    for (int i = 0; i < 5; i++) wq.push_back({4'b0001, 10'(32'h020 + i), 32'h100 + i});
    d0 = done_cnt; w0 = wr_cnt;
    send_cmd(1'b0, 0, 1'b0, 'h020, 16);
    for (int i = 0; i < 5; i++) send_word(32'h100 + i);
    wd_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_mid_writes", 64'(wr_cnt - w0), 64'd5);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_mid_queue_empty", 64'(wq.size()), 64'd0);
    chk("rst_mid_idle", {cmd_ready, busy}, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
